// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the 24-hour alarm clock.
package clock_pkg;
    localparam int CLK_DIV_DEF   = 10;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int SEC_PER_MIN   = 60;

    function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
        return 6'(tens) * 6'd10 + 6'(units);
    endfunction
endpackage

// File: rtl/clock_if.sv
// Load/control inputs and BCD display/alarm outputs of the alarm clock.
interface clock_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [2:0] M_out1;
    logic [3:0] M_out0;
    logic [2:0] S_out1;
    logic [3:0] S_out0;

    modport master (
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
        input  Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
    );
    modport slave (
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
        output Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
    );
endinterface

// File: rtl/clock_bin2bcd_digits.sv
// Splits a 0..59 binary value into BCD tens and units digits.
module bin2bcd_digits #(
    parameter int TENS_W = 3
) (
    input  logic [5:0]        i_val,
    output logic [TENS_W-1:0] o_tens,
    output logic [3:0]        o_units
);
    assign o_tens  = TENS_W'(i_val / 6'd10);
    assign o_units = 4'(i_val % 6'd10);
endmodule

// File: rtl/clock.sv
// 24-hour hh:mm:ss clock with a CLK_DIV prescaler, loadable time/alarm and latched Alarm.
module clock
    import clock_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic    clk,
    input  logic    reset,
    clock_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0] SEC_LAST  = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_PER_HOUR - 1);
    localparam logic [5:0] HOUR_LAST = 6'(HOURS_PER_DAY - 1);

    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_hh, r_mm, r_ss;
    logic [5:0]       r_al_hh, r_al_mm;
    logic             r_alarm;

    logic [5:0] w_ld_hh, w_ld_mm;
    logic       w_tick, w_match;

    assign w_ld_hh = bcd2bin(4'(bus.H_in1), bus.H_in0);
    assign w_ld_mm = bcd2bin(4'(bus.M_in1), bus.M_in0);
    assign w_tick  = (r_div == DIV_LAST);
    // Compared against the registered time, so Alarm lags the :00 display by one clk.
    assign w_match = (r_hh == r_al_hh) && (r_mm == r_al_mm) && (r_ss == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hh    <= w_ld_hh;
            r_mm    <= w_ld_mm;
            r_ss    <= 6'd0;
            r_al_hh <= 6'd0;
            r_al_mm <= 6'd0;
            r_div   <= '0;
            r_alarm <= 1'b0;
        end else begin
            if (bus.LD_time) begin
                r_hh  <= w_ld_hh;
                r_mm  <= w_ld_mm;
                r_ss  <= 6'd0;
                r_div <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                if (r_ss == SEC_LAST) begin
                    r_ss <= 6'd0;
                    if (r_mm == MIN_LAST) begin
                        r_mm <= 6'd0;
                        r_hh <= (r_hh >= HOUR_LAST) ? 6'd0 : r_hh + 6'd1;
                    end else begin
                        r_mm <= r_mm + 6'd1;
                    end
                end else begin
                    r_ss <= r_ss + 6'd1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (bus.LD_alarm) begin
                r_al_hh <= w_ld_hh;
                r_al_mm <= w_ld_mm;
            end

            if (bus.STOP_al || !bus.AL_ON)
                r_alarm <= 1'b0;
            else if (w_match)
                r_alarm <= 1'b1;
        end
    end

    assign bus.Alarm = r_alarm;

    bin2bcd_digits #(.TENS_W(2)) u_hh (.i_val(r_hh), .o_tens(bus.H_out1), .o_units(bus.H_out0));
    bin2bcd_digits #(.TENS_W(3)) u_mm (.i_val(r_mm), .o_tens(bus.M_out1), .o_units(bus.M_out0));
    bin2bcd_digits #(.TENS_W(3)) u_ss (.i_val(r_ss), .o_tens(bus.S_out1), .o_units(bus.S_out0));
endmodule

// File: tb/tb_clock.sv
// Scoreboard bench for the alarm clock: expectations are queued with the cycle they are due.
module tb_clock;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_if bus();
    clock #(.CLK_DIV(10)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        int         at;
        bit         is_al;
        logic [19:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t it;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, ncyc);
        end
    endtask

    // sec is seconds since midnight; packs the six expected display digits
    function automatic logic [19:0] disp(input int sec);
        int t, h, m, s;
        t = sec % 86400;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push_t(input string tag, input int at, input int sec);
        sb.push_back('{tag, at, 1'b0, disp(sec)});
    endtask

    task automatic push_a(input string tag, input int at, input bit v);
        sb.push_back('{tag, at, 1'b1, 20'(v)});
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= ncyc) begin
            it = sb.pop_front();
            if (it.at < ncyc)
                chk({it.tag, "_late"}, 32'(ncyc), 32'(it.at));
            else if (it.is_al)
                chk(it.tag, 32'(bus.Alarm), 32'(it.exp));
            else
                chk(it.tag, 32'({bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0,
                                 bus.S_out1, bus.S_out0}), 32'(it.exp));
        end
    end

    task automatic wait_to(input int at);
        while (ncyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input int h1, input int h0, input int m1, input int m0);
        bus.H_in1 = 2'(h1);
        bus.H_in0 = 4'(h0);
        bus.M_in1 = 3'(m1);
        bus.M_in0 = 4'(m0);
    endtask

    initial begin
        int r, l, b;
        reset = 1'b1;
        bus.LD_time = 1'b0;
        bus.LD_alarm = 1'b0;
        bus.STOP_al = 1'b0;
        bus.AL_ON = 1'b0;
        set_in(1, 0, 1, 4);

        // reset held 10 clk, then free-running seconds
        wait_to(10);
        reset = 1'b0;
        r = 10;
        b = 10 * 3600 + 14 * 60;
        push_t("rst_time", r, b);
        push_a("rst_alarm", r, 1'b0);
        push_t("tick9", r + 9, b);
        push_t("tick10", r + 10, b + 1);
        push_t("tick20", r + 20, b + 2);

        // alarm at 10:20
        wait_to(11);
        set_in(1, 0, 2, 0);
        bus.LD_alarm = 1'b1;
        bus.AL_ON = 1'b1;
        wait_to(12);
        bus.LD_alarm = 1'b0;
        push_t("t1020", r + 3600, b + 360);
        push_a("al1020_pre", r + 3600, 1'b0);
        push_a("al1020_rise", r + 3601, 1'b1);
        push_t("t102001", r + 3610, b + 361);
        push_a("al1020_hold", r + 3611, 1'b1);

        // silence with STOP_al for 10 clk
        wait_to(r + 3615);
        bus.STOP_al = 1'b1;
        push_a("stop_clr", r + 3616, 1'b0);
        wait_to(r + 3625);
        bus.STOP_al = 1'b0;
        push_a("stop_rel", r + 3630, 1'b0);

        // load 04:45, alarm 04:55
        wait_to(r + 3630);
        l = ncyc + 1;
        set_in(0, 4, 4, 5);
        bus.LD_time = 1'b1;
        push_t("ld0445", l, 4 * 3600 + 45 * 60);
        wait_to(l);
        bus.LD_time = 1'b0;
        set_in(0, 4, 5, 5);
        bus.LD_alarm = 1'b1;
        wait_to(l + 1);
        bus.LD_alarm = 1'b0;
        push_t("t0455", l + 6000, 4 * 3600 + 55 * 60);
        push_a("al0455_pre", l + 6000, 1'b0);
        push_a("al0455_rise", l + 6001, 1'b1);
        wait_to(l + 6004);
        bus.AL_ON = 1'b0;
        push_a("alon_clr", l + 6005, 1'b0);

        // same match with AL_ON low must stay silent
        wait_to(l + 6009);
        l = ncyc + 1;
        set_in(0, 4, 4, 5);
        bus.LD_time = 1'b1;
        wait_to(l);
        bus.LD_time = 1'b0;
        push_t("off_t0455", l + 6000, 4 * 3600 + 55 * 60);
        push_a("off_match", l + 6001, 1'b0);
        push_a("off_match2", l + 6005, 1'b0);

        // midnight wrap
        wait_to(l + 6009);
        l = ncyc + 1;
        set_in(2, 3, 5, 9);
        bus.LD_time = 1'b1;
        wait_to(l);
        bus.LD_time = 1'b0;
        push_t("pre_wrap", l + 599, 86399);
        push_t("wrap", l + 600, 0);

        // 09:59:59 -> 10:00:00
        wait_to(l + 605);
        l = ncyc + 1;
        set_in(0, 9, 5, 9);
        bus.LD_time = 1'b1;
        wait_to(l);
        bus.LD_time = 1'b0;
        push_t("pre_carry", l + 599, 9 * 3600 + 59 * 60 + 59);
        push_t("carry", l + 600, 10 * 3600);

        // immediate match, then reset mid-count
        wait_to(l + 605);
        l = ncyc + 1;
        set_in(0, 4, 5, 5);
        bus.AL_ON = 1'b1;
        bus.LD_time = 1'b1;
        wait_to(l);
        bus.LD_time = 1'b0;
        push_a("imm_rise", l + 1, 1'b1);
        wait_to(l + 5);
        reset = 1'b1;
        r = l + 6;
        b = 4 * 3600 + 55 * 60;
        push_a("rstmid_al", r, 1'b0);
        push_t("rstmid_t", r, b);
        push_t("rstmid_div4", r + 4, b);
        push_t("rstmid_div9", r + 9, b);
        push_t("rstmid_div10", r + 10, b + 1);
        push_a("rstmid_al2", r + 10, 1'b0);
        wait_to(r);
        reset = 1'b0;

        wait_to(r + 20);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clock.md
Name: clock

Overview:
- 24-hour alarm clock with a time-of-day counter (hh:mm:ss) advanced once per second by a divided-down system clock.
- Has a loadable alarm time (hh:mm) and a latched Alarm output.
- Current time is presented as BCD digits for a display driver.
- Time and alarm are loaded from BCD digit inputs.

Parameters:
- CLK_DIV, 10, number of clk cycles per one-second tick (10 Hz clk).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- H_in1  in  2  hours tens digit (BCD) for load
- H_in0  in  4  hours units digit (BCD) for load
- M_in1  in  3  minutes tens digit (BCD) for load
- M_in0  in  4  minutes units digit (BCD) for load
- LD_time  in  1  load current time from H_in*/M_in*
- LD_alarm  in  1  load alarm time from H_in*/M_in*
- STOP_al  in  1  clear (silence) Alarm
- AL_ON  in  1  alarm enable
- Alarm  out  1  alarm active, registered
- H_out1  out  2  current hours tens digit
- H_out0  out  4  current hours units digit
- M_out1  out  3  current minutes tens digit
- M_out0  out  4  current minutes units digit
- S_out1  out  3  current seconds tens digit
- S_out0  out  4  current seconds units digit

Behaviour:
- Internal state:
  - time hours 0-23, minutes 0-59, seconds 0-59 (binary).
  - alarm hours and minutes (alarm seconds fixed at 0).
  - tick divider counting 0..CLK_DIV-1.
- Input conversion: value = tens*10 + units. Inputs are assumed valid BCD; no range checking.
- Reset (highest priority, synchronous):
  - time <= loaded inputs, seconds <= 0.
  - alarm <= 00:00.
  - divider <= 0.
  - Alarm <= 0.
- LD_time:
  - time <= inputs, seconds <= 0, divider <= 0.
  - Overrides any tick in the same cycle.
- LD_alarm: alarm <= inputs. May coincide with LD_time; both loads occur.
- Tick:
  - When neither reset nor LD_time is active, divider increments.
  - On divider == CLK_DIV-1, divider wraps to 0 and time advances one second in the same cycle.
  - Seconds 59 -> 0 carries into minutes.
  - Minutes 59 -> 0 carries into hours.
  - Hours >= 23 wrap to 0 on carry, so 23:59:59 -> 00:00:00.
- Alarm, priority order each cycle:
  - reset -> 0
  - STOP_al=1 or AL_ON=0 -> 0
  - registered time == alarm hh:mm:00 and AL_ON=1 -> 1
  - else hold
- Alarm rises one clk after time reaches hh:mm:00 and stays high (latched) until STOP_al, AL_ON low, or reset.
- If STOP_al is released while time still equals hh:mm:00, Alarm re-asserts.
- A match triggers at most once per day, because seconds leave :00 after CLK_DIV cycles.
- Outputs:
  - Digit outputs are combinational binary-to-BCD splits of the time registers (tens = v/10, units = v%10).
  - Digit outputs update in the cycle after a load or tick.

Decomposition:
- Shared package holds:
  - CLK_DIV default
  - constants HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60
  - a function bcd2bin(tens, units)
- One natural sub-module: bin2bcd_digits (6-bit value -> tens/units).
  - Instantiated three times, for hours, minutes and seconds.

Test Plan:
- Reset with inputs 1,0,1,4, held 10 clk: outputs 10:14:00, Alarm=0; after release, S_out0 increments every 10 clk.
- After reset (10:14), LD_alarm with 1,0,2,0 and AL_ON=1: Alarm rises exactly 1 clk after outputs show 10:20:00 (about 3600 clk later); it stays high past 10:20:01.
- With Alarm high, pulse STOP_al for 10 clk: Alarm=0 on the next clk and remains 0 after STOP_al drops (time now past :00).
- LD_time 0,4,4,5 then LD_alarm 0,4,5,5 with AL_ON=1: outputs 04:45:00 right after the load; Alarm rises at 04:55:00.
- Wrap: LD_time 2,3,5,9, wait 600 clk: outputs 00:00:00 after 23:59:59. Also check 09:59:59 -> 10:00:00 digit carry.
- Same setup as the 04:55 case but with AL_ON=0 at the match: Alarm stays 0. Dropping AL_ON while Alarm is high clears it next clk. reset mid-count returns the divider to 0 and Alarm to 0.
